// File: rtl/mem_port_responder_if.sv
// Request/response bus between the multicycle control unit (master) and the memory responder (slave).
interface mem_port_responder_if;
    logic        Req;
    logic        ReqWrite;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        Ready;
    logic        RValid;
    logic [31:0] RData;
    logic        WDone;
    logic        Err;

    modport master (
        output Req, ReqWrite, Addr, WData,
        input  Ready, RValid, RData, WDone, Err
    );

    modport slave (
        input  Req, ReqWrite, Addr, WData,
        output Ready, RValid, RData, WDone, Err
    );
endinterface

// File: rtl/mem_port_responder.sv
// Fixed-latency single-request word memory responder (IDLE -> WAIT -> RESP -> IDLE).
// Optional feature: define MISALIGN_TRAP_EN to answer misaligned requests with an Err pulse.
module mem_port_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    mem_port_responder_if.slave  bus
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    count;
    logic          cap_write;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;

    logic          ready_q;
    logic          rvalid_q;
    logic          wdone_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic [31:0]   mem [DEPTH];

    logic          enter_resp;
    logic          acc_write;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [AW-1:0] acc_idx;
    logic          acc_mis;
    logic          mem_we;
    logic          unused_bits;

    // With zero latency the access happens on the accepting edge, so the live inputs
    // stand in for the not-yet-captured request fields.
    assign acc_write = (state == IDLE) ? bus.ReqWrite : cap_write;
    assign acc_addr  = (state == IDLE) ? bus.Addr     : cap_addr;
    assign acc_wdata = (state == IDLE) ? bus.WData    : cap_wdata;
    assign acc_idx   = acc_addr[AW+1:2];

    assign enter_resp = ((state == IDLE) && bus.Req && (LATENCY == 0)) ||
                        ((state == WAIT) && (count == 4'd1));

`ifdef MISALIGN_TRAP_EN
    assign acc_mis     = (acc_addr[1:0] != 2'b00);
    assign bus.Err     = err_q;
    assign unused_bits = ^{acc_addr[31:AW+2]};
`else
    assign acc_mis     = 1'b0;
    assign bus.Err     = 1'b0;
    assign unused_bits = ^{acc_addr[31:AW+2], acc_addr[1:0], err_q};
`endif

    assign mem_we = enter_resp && acc_write && !acc_mis && !Reset;

    assign bus.Ready  = ready_q;
    assign bus.RValid = rvalid_q;
    assign bus.WDone  = wdone_q;
    assign bus.RData  = rdata_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            cap_write <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            ready_q   <= 1'b1;
            rvalid_q  <= 1'b0;
            wdone_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Req) begin
                        cap_write <= bus.ReqWrite;
                        cap_addr  <= bus.Addr;
                        cap_wdata <= bus.WData;
                        count     <= LAT;
                        ready_q   <= 1'b0;
                        state     <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
            if (enter_resp) begin
                rvalid_q <= !acc_write && !acc_mis;
                wdone_q  <= acc_write && !acc_mis;
                err_q    <= acc_mis;
                if (!acc_write && !acc_mis) begin
                    rdata_q <= mem[acc_idx];
                end
            end
        end
    end

    // The array is deliberately left without reset; it only changes on a committed write.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed self-checking bench: a LATENCY=2 responder and a LATENCY=0 responder share clock and reset.
module tb_mem_port_responder;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    mem_port_responder_if a ();
    mem_port_responder_if b ();

    mem_port_responder #(.DEPTH(256), .LATENCY(2)) dut_a (.Clk(Clk), .Reset(Reset), .bus(a.slave));
    mem_port_responder #(.DEPTH(256), .LATENCY(0)) dut_b (.Clk(Clk), .Reset(Reset), .bus(b.slave));

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pulses_a();
        return {29'd0, a.RValid, a.WDone, a.Err};
    endfunction

    function automatic logic [31:0] pulses_b();
        return {29'd0, b.RValid, b.WDone, b.Err};
    endfunction

    // One LATENCY=2 transaction; exp_pulse is {RValid,WDone,Err}. Inputs are scrambled after
    // acceptance, and with busy=1 Req stays high through WAIT and RESP.
    task automatic access_a(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] exp_pulse,
                            input logic [31:0] exp_rdata, input bit busy);
        @(negedge Clk);
        a.Req = 1'b1; a.ReqWrite = wr; a.Addr = addr; a.WData = wdata;
        @(negedge Clk);
        a.Req = busy; a.ReqWrite = ~wr; a.Addr = addr ^ 32'h0000_0044; a.WData = ~wdata;
        check({tag, " ready k0"}, {31'd0, a.Ready}, 32'd0);
        check({tag, " pulse k0"}, pulses_a(), 32'd0);
        @(negedge Clk);
        check({tag, " ready k1"}, {31'd0, a.Ready}, 32'd0);
        check({tag, " pulse k1"}, pulses_a(), 32'd0);
        @(negedge Clk);
        check({tag, " pulse resp"}, pulses_a(), {29'd0, exp_pulse});
        check({tag, " ready resp"}, {31'd0, a.Ready}, 32'd0);
        check({tag, " rdata resp"}, a.RData, exp_rdata);
        a.Req = 1'b0;
        @(negedge Clk);
        check({tag, " pulse after"}, pulses_a(), 32'd0);
        check({tag, " ready after"}, {31'd0, a.Ready}, 32'd1);
        check({tag, " rdata hold"}, a.RData, exp_rdata);
        @(negedge Clk);
        check({tag, " pulse idle"}, pulses_a(), 32'd0);
        check({tag, " ready idle"}, {31'd0, a.Ready}, 32'd1);
    endtask

    task automatic access_b(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] exp_pulse,
                            input logic [31:0] exp_rdata);
        @(negedge Clk);
        b.Req = 1'b1; b.ReqWrite = wr; b.Addr = addr; b.WData = wdata;
        @(negedge Clk);
        b.Req = 1'b0;
        check({tag, " pulse resp"}, pulses_b(), {29'd0, exp_pulse});
        check({tag, " ready resp"}, {31'd0, b.Ready}, 32'd0);
        check({tag, " rdata resp"}, b.RData, exp_rdata);
        @(negedge Clk);
        check({tag, " pulse after"}, pulses_b(), 32'd0);
        check({tag, " ready after"}, {31'd0, b.Ready}, 32'd1);
    endtask

    initial begin
        a.Req = 1'b0; a.ReqWrite = 1'b0; a.Addr = 32'd0; a.WData = 32'd0;
        b.Req = 1'b0; b.ReqWrite = 1'b0; b.Addr = 32'd0; b.WData = 32'd0;
        $display("[TB] start");

        #12;
        check("reset a ready", {31'd0, a.Ready}, 32'd1);
        check("reset a pulses", pulses_a(), 32'd0);
        check("reset a rdata", a.RData, 32'd0);
        check("reset b ready", {31'd0, b.Ready}, 32'd1);
        check("reset b pulses", pulses_b(), 32'd0);
        check("reset b rdata", b.RData, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        access_a("wr 0x10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0000_0000, 1'b0);
        access_a("rd 0x10 busy", 1'b0, 32'h0000_0010, 32'h0, 3'b100, 32'hDEAD_BEEF, 1'b1);
        access_a("wr 0x400", 1'b1, 32'h0000_0400, 32'h1234_5678, 3'b010, 32'hDEAD_BEEF, 1'b1);
        access_a("rd 0x000 wrap", 1'b0, 32'h0000_0000, 32'h0, 3'b100, 32'h1234_5678, 1'b0);

        access_b("b wr 0x8", 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 3'b010, 32'h0000_0000);
        access_b("b rd 0x8", 1'b0, 32'h0000_0008, 32'h0, 3'b100, 32'hCAFE_F00D);

        access_a("wr 0x20 prior", 1'b1, 32'h0000_0020, 32'h1111_2222, 3'b010, 32'h1234_5678, 1'b0);

        // Abort a write of the same word while it sits in WAIT.
        @(negedge Clk);
        a.Req = 1'b1; a.ReqWrite = 1'b1; a.Addr = 32'h0000_0020; a.WData = 32'hA5A5_A5A5;
        @(negedge Clk);
        a.Req = 1'b0;
        check("abort ready before", {31'd0, a.Ready}, 32'd0);
        #1 Reset = 1'b1;
        #1;
        check("abort ready", {31'd0, a.Ready}, 32'd1);
        check("abort rdata", a.RData, 32'd0);
        check("abort pulses", pulses_a(), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check($sformatf("abort no wdone %0d", i), pulses_a(), 32'd0);
        end

        access_a("rd 0x20 unchanged", 1'b0, 32'h0000_0020, 32'h0, 3'b100, 32'h1111_2222, 1'b0);

`ifdef MISALIGN_TRAP_EN
        access_a("misaligned wr 0x22", 1'b1, 32'h0000_0022, 32'h0000_0001, 3'b001, 32'h1111_2222, 1'b0);
        access_a("rd 0x20 after trap", 1'b0, 32'h0000_0020, 32'h0, 3'b100, 32'h1111_2222, 1'b0);
`else
        access_a("misaligned wr 0x22", 1'b1, 32'h0000_0022, 32'h0000_0001, 3'b010, 32'h1111_2222, 1'b0);
        access_a("rd 0x20 after wr", 1'b0, 32'h0000_0020, 32'h0, 3'b100, 32'h0000_0001, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
